// File: rtl/psg_multi_ch_if.sv
// Mapper-side register bus of the sound generator: index/data write strobes,
// shared write data and combinational readback.
interface psg_multi_ch_if;
  logic       addr_wr;
  logic       data_wr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output addr_wr, output data_wr, output din, input dout);
  modport slave  (input addr_wr, input data_wr, input din, output dout);
endinterface

// File: rtl/psg_multi_ch.sv
// AY/YM-class sound generator: NUM_CH square tones, shared 17-bit noise LFSR,
// 16-shape envelope, log volume and a two-stage registered saturating mix.
module psg_multi_ch #(
  parameter int NUM_CH  = 3,
  parameter int CLK_DIV = 16,
  parameter int GAIN    = 5,
  parameter int OUT_W   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  psg_multi_ch_if.slave      bus,
  output logic [OUT_W-1:0]   audio_out
);

  localparam logic [4:0] IDX_NOISE = 5'(2*NUM_CH);
  localparam logic [4:0] IDX_MIX   = 5'(2*NUM_CH + 1);
  localparam logic [4:0] IDX_VOL   = 5'(2*NUM_CH + 2);
  localparam logic [4:0] IDX_EPL   = 5'(3*NUM_CH + 2);
  localparam logic [4:0] IDX_EPH   = 5'(3*NUM_CH + 3);
  localparam logic [4:0] IDX_SHAPE = 5'(3*NUM_CH + 4);
  localparam int         PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [63:0] GAIN64   = 64'(GAIN);
  localparam logic [63:0] MAXV     = (64'd1 << OUT_W) - 64'd1;
  localparam logic [7:0] LUT [32] = '{
    8'd0,   8'd1,   8'd2,   8'd3,   8'd3,   8'd4,   8'd5,   8'd6,
    8'd8,   8'd9,   8'd11,  8'd13,  8'd16,  8'd18,  8'd24,  8'd29,
    8'd32,  8'd34,  8'd44,  8'd55,  8'd61,  8'd66,  8'd82,  8'd98,
    8'd114, 8'd130, 8'd148, 8'd166, 8'd187, 8'd207, 8'd231, 8'd255};

  logic [4:0]          reg_idx;
  logic [11:0]         tone_per [NUM_CH];
  logic [4:0]          noise_per;
  logic [2*NUM_CH-1:0] mixer;
  logic [4:0]          vol [NUM_CH];
  logic [15:0]         env_per;
  logic [3:0]          shape;

  logic [PW-1:0]       presc;
  logic                tick;
  logic [11:0]         tone_cnt [NUM_CH];
  logic [11:0]         tone_lim [NUM_CH];
  logic [NUM_CH-1:0]   tone_sq;
  logic [4:0]          noise_cnt, noise_lim;
  logic [16:0]         lfsr;
  logic [15:0]         env_cnt, env_lim;
  logic [4:0]          env_step, env_lvl;
  logic                env_dir, env_hold;
  logic                shape_wr;
  logic [NUM_CH-1:0]   gate;
  logic [4:0]          lvl5 [NUM_CH];
  logic [7:0]          lut_d [NUM_CH];
  logic [7:0]          lut_q [NUM_CH];
  logic [9:0]          mix_sum;
  logic [63:0]         mix_prod;
  logic [7:0]          dout_c;

  // Register file; a same-cycle data write still targets the old index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_idx   <= '0;
      noise_per <= '0;
      mixer     <= '0;
      env_per   <= '0;
      shape     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        tone_per[c] <= '0;
        vol[c]      <= '0;
      end
    end else begin
      if (bus.addr_wr) reg_idx <= bus.din[4:0];
      if (bus.data_wr) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (reg_idx == 5'(2*c))         tone_per[c][7:0]  <= bus.din;
          if (reg_idx == 5'(2*c + 1))     tone_per[c][11:8] <= bus.din[3:0];
          if (reg_idx == IDX_VOL + 5'(c)) vol[c]            <= bus.din[4:0];
        end
        if (reg_idx == IDX_NOISE) noise_per     <= bus.din[4:0];
        if (reg_idx == IDX_MIX)   mixer         <= bus.din[2*NUM_CH-1:0];
        if (reg_idx == IDX_EPL)   env_per[7:0]  <= bus.din;
        if (reg_idx == IDX_EPH)   env_per[15:8] <= bus.din;
        if (reg_idx == IDX_SHAPE) shape         <= bus.din[3:0];
      end
    end
  end

  always_comb begin
    dout_c = 8'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (reg_idx == 5'(2*c))         dout_c = tone_per[c][7:0];
      if (reg_idx == 5'(2*c + 1))     dout_c = {4'd0, tone_per[c][11:8]};
      if (reg_idx == IDX_VOL + 5'(c)) dout_c = {3'd0, vol[c]};
    end
    if (reg_idx == IDX_NOISE) dout_c = {3'd0, noise_per};
    if (reg_idx == IDX_MIX)   dout_c = 8'(mixer);
    if (reg_idx == IDX_EPL)   dout_c = env_per[7:0];
    if (reg_idx == IDX_EPH)   dout_c = env_per[15:8];
    if (reg_idx == IDX_SHAPE) dout_c = {4'd0, shape};
  end

  assign bus.dout = dout_c;
  assign tick     = (presc == PW'(CLK_DIV - 1));
  assign shape_wr = bus.data_wr && (reg_idx == IDX_SHAPE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  // A period of 0 behaves as 1; counters compare with >= so a shrunken period wraps at once
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      tone_lim[c] = (tone_per[c] == 12'd0) ? 12'd0 : tone_per[c] - 12'd1;
    noise_lim = (noise_per == 5'd0) ? 5'd0 : noise_per - 5'd1;
    env_lim   = (env_per == 16'd0) ? 16'd0 : env_per - 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_sq <= '0;
      for (int c = 0; c < NUM_CH; c++) tone_cnt[c] <= '0;
    end else if (tick) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (tone_cnt[c] >= tone_lim[c]) begin
          tone_cnt[c] <= '0;
          tone_sq[c]  <= ~tone_sq[c];
        end else begin
          tone_cnt[c] <= tone_cnt[c] + 12'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      noise_cnt <= '0;
      lfsr      <= 17'h00001;
    end else if (tick) begin
      if (noise_cnt >= noise_lim) begin
        noise_cnt <= '0;
        lfsr      <= {lfsr[15:0], lfsr[16] ^ lfsr[13]};
      end else begin
        noise_cnt <= noise_cnt + 5'd1;
      end
    end
  end

  // Envelope: shape bits are {CONT, ATT, ALT, HOLD}; end-of-ramp action chosen at step 31
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_cnt  <= '0;
      env_step <= '0;
      env_dir  <= 1'b0;
      env_hold <= 1'b0;
    end else if (shape_wr) begin
      env_cnt  <= '0;
      env_step <= '0;
      env_dir  <= bus.din[2];
      env_hold <= 1'b0;
    end else if (tick && !env_hold) begin
      if (env_cnt >= env_lim) begin
        env_cnt <= '0;
        if (env_step == 5'd31) begin
          if (!shape[3]) begin
            env_step <= '0;
            env_dir  <= 1'b1;
            env_hold <= 1'b1;
          end else if (shape[0]) begin
            env_dir  <= env_dir ^ shape[1];
            env_hold <= 1'b1;
          end else begin
            env_step <= '0;
            if (shape[1]) env_dir <= ~env_dir;
          end
        end else begin
          env_step <= env_step + 5'd1;
        end
      end else begin
        env_cnt <= env_cnt + 16'd1;
      end
    end
  end

  assign env_lvl = env_dir ? env_step : 5'd31 - env_step;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      gate[c]  = (tone_sq[c] | mixer[c]) & (lfsr[0] | mixer[NUM_CH + c]);
      lvl5[c]  = vol[c][4] ? env_lvl
               : ((vol[c][3:0] == 4'd0) ? 5'd0 : {vol[c][3:0], 1'b1});
      lut_d[c] = gate[c] ? LUT[lvl5[c]] : 8'd0;
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int c = 0; c < NUM_CH; c++) mix_sum = mix_sum + 10'(lut_q[c]);
    mix_prod = 64'(mix_sum) * GAIN64;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_out <= '0;
      for (int c = 0; c < NUM_CH; c++) lut_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) lut_q[c] <= lut_d[c];
      audio_out <= (mix_prod > MAXV) ? OUT_W'(MAXV) : OUT_W'(mix_prod);
    end
  end

endmodule

// File: tb/tb_psg_multi_ch.sv
// Directed bench: a 3-channel core at CLK_DIV=1 for tone/envelope/register work
// and a 4-channel core at default CLK_DIV for prescaler and saturation.
module tb_psg_multi_ch;

  logic        clk;
  logic        rst_n;
  logic [11:0] audio3, audio4;
  int          check_cnt, pass_cnt;

  psg_multi_ch_if bus3();
  psg_multi_ch_if bus4();

  psg_multi_ch #(.NUM_CH(3), .CLK_DIV(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .audio_out(audio3));

  psg_multi_ch #(.NUM_CH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .audio_out(audio4));

  int lut [32] = '{0, 1, 2, 3, 3, 4, 5, 6, 8, 9, 11, 13, 16, 18, 24, 29,
                   32, 34, 44, 55, 61, 66, 82, 98, 114, 130, 148, 166, 187, 207, 231, 255};
  int rb_mask [14] = '{8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'h1F,
                       8'h3F, 8'h1F, 8'h1F, 8'h1F, 8'hFF, 8'hFF, 8'h0F};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic drive(input bit sel, input logic aw, input logic dw, input logic [7:0] d);
    if (sel) begin
      bus4.addr_wr = aw; bus4.data_wr = dw; bus4.din = d;
    end else begin
      bus3.addr_wr = aw; bus3.data_wr = dw; bus3.din = d;
    end
  endtask

  function automatic int rd(input bit sel);
    return sel ? int'(bus4.dout) : int'(bus3.dout);
  endfunction

  task automatic selectIndex(input bit sel, input logic [4:0] idx);
    @(negedge clk); drive(sel, 1'b1, 1'b0, {3'd0, idx});
    @(negedge clk); drive(sel, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic applyStimulus(input bit sel, input logic [4:0] idx, input logic [7:0] val);
    selectIndex(sel, idx);
    drive(sel, 1'b0, 1'b1, val);
    @(negedge clk); drive(sel, 1'b0, 1'b0, 8'd0);
  endtask

  // Expected envelope level k ticks after a restart with EP=1
  function automatic int env_expect(input logic [3:0] shp, input int k);
    case (shp)
      4'hA:    return (k < 32) ? 31 - k : ((k < 64) ? k - 32 : 95 - k);
      4'h9:    return (k < 32) ? 31 - k : 0;
      4'hD:    return (k < 32) ? k : 31;
      default: return (k < 32) ? k : ((k < 64) ? 63 - k : k - 64);
    endcase
  endfunction

  task automatic run_env(input logic [3:0] shp, input int kmax);
    applyStimulus(0, 5'd13, {4'd0, shp});
    @(posedge clk);
    for (int k = 0; k <= kmax; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("env%h_k%0d", shp, k), int'(audio3), lut[env_expect(shp, k)] * 5);
    end
  endtask

  initial begin
    int hist [4];
    int prev_a, tog;
    bit found;
    check_cnt = 0;
    pass_cnt  = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'd0);
    drive(1, 1'b0, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    checkOutput("rst_audio3", int'(audio3), 0);
    checkOutput("rst_audio4", int'(audio4), 0);
    checkOutput("rst_lfsr3", int'(dut3.lfsr), 1);
    rst_n = 1'b1;

    // LFSR first step: every clock on dut3, on the 16th clock on dut4
    @(posedge clk); #1;
    checkOutput("lfsr3_step1", int'(dut3.lfsr), 2);
    repeat (14) @(posedge clk);
    #1;
    checkOutput("lfsr4_before_tick", int'(dut4.lfsr), 1);
    @(posedge clk); #1;
    checkOutput("lfsr4_first_tick", int'(dut4.lfsr), 2);
    checkOutput("idle_audio3", int'(audio3), 0);
    checkOutput("idle_dout3", rd(0), 0);
    checkOutput("idle_dout4", rd(1), 0);

    // Tone: half-period 4 clocks, level 7 -> LUT[15]=29, x5
    applyStimulus(0, 5'd0, 8'd4);
    applyStimulus(0, 5'd7, 8'h3E);
    applyStimulus(0, 5'd8, 8'h07);
    found  = 1'b0;
    prev_a = 0;
    hist   = '{0, 0, 0, 0};
    for (int n = 0; n < 40 && !found; n++) begin
      @(posedge clk); #1;
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0];
      hist[0] = int'(dut3.tone_sq[0]);
      if (n >= 3 && audio3 == 12'd145 && prev_a == 0) found = 1'b1;
      prev_a = int'(audio3);
    end
    if (!found) begin
      checkOutput("tone_edge_timeout", 0, 1);
    end else begin
      checkOutput("tone_lat_sq_t2", hist[2], 1);
      checkOutput("tone_lat_sq_t3", hist[3], 0);
      for (int m = 1; m <= 8; m++) begin
        @(posedge clk); #1;
        if (m == 3) checkOutput("tone_hi_end", int'(audio3), 145);
        if (m == 4) checkOutput("tone_lo_start", int'(audio3), 0);
        if (m == 7) checkOutput("tone_lo_end", int'(audio3), 0);
        if (m == 8) checkOutput("tone_hi_again", int'(audio3), 145);
      end
    end

    // Period 0 and period 1 both toggle every tick
    for (int p = 0; p < 2; p++) begin
      applyStimulus(0, 5'd0, 8'(p));
      repeat (3) @(posedge clk);
      #1;
      prev_a = int'(audio3);
      tog = 0;
      for (int n = 0; n < 8; n++) begin
        @(posedge clk); #1;
        if (int'(audio3) != prev_a) tog++;
        prev_a = int'(audio3);
      end
      checkOutput($sformatf("tone_p%0d_toggles", p), tog, 8);
    end
    applyStimulus(0, 5'd1, 8'hFF);
    checkOutput("tone_hi_readback", rd(0), 8'h0F);
    applyStimulus(0, 5'd1, 8'h00);

    // Envelope on ch0 with gate forced open, EP=1
    applyStimulus(0, 5'd7, 8'h3F);
    applyStimulus(0, 5'd8, 8'h10);
    applyStimulus(0, 5'd11, 8'h01);
    applyStimulus(0, 5'd12, 8'h00);
    run_env(4'hA, 66);
    run_env(4'h9, 40);
    run_env(4'hE, 66);
    run_env(4'hD, 40);

    // Saturation on the 4-channel core: 3x255x5=3825, 4x255x5=5100 -> 4095
    applyStimulus(1, 5'd9, 8'hFF);
    applyStimulus(1, 5'd10, 8'h0F);
    applyStimulus(1, 5'd11, 8'h0F);
    applyStimulus(1, 5'd12, 8'h0F);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mix3_unsat", int'(audio4), 3825);
    applyStimulus(1, 5'd13, 8'h0F);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mix4_sat", int'(audio4), 4095);

    // Asynchronous reset mid-operation
    checkOutput("env_held_pre_rst", int'(audio3), 1275);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_audio3", int'(audio3), 0);
    checkOutput("midrst_audio4", int'(audio4), 0);
    checkOutput("midrst_dout4", rd(1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("post_rst_audio4", int'(audio4), 0);

    // Unused bits dropped on write; out-of-range indices ignored and read 0
    for (int i = 0; i < 14; i++) applyStimulus(0, 5'(i), 8'hFF);
    applyStimulus(0, 5'd20, 8'h00);
    checkOutput("rd_idx20", rd(0), 0);
    applyStimulus(0, 5'd14, 8'h00);
    checkOutput("rd_idx14", rd(0), 0);
    for (int i = 0; i < 14; i++) begin
      selectIndex(0, 5'(i));
      checkOutput($sformatf("mask_reg%0d", i), rd(0), rb_mask[i]);
    end

    // Same-cycle index and data write: data lands in reg8, index becomes 10
    selectIndex(0, 5'd8);
    @(negedge clk); drive(0, 1'b1, 1'b1, 8'hAA);
    @(negedge clk); drive(0, 1'b0, 1'b0, 8'h00);
    checkOutput("same_cycle_idx10", rd(0), 8'h1F);
    selectIndex(0, 5'd8);
    checkOutput("same_cycle_reg8", rd(0), 8'h0A);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
